// File: rtl/gerenciador_saidas_bcd_seq.sv
// gerenciador_saidas_bcd_seq: sequential binary-to-BCD display manager (double dabble, one bit per clock)
// Ports:
//   clk      - system clock, rising edge
//   rst_n    - synchronous active-low reset
//   start    - conversion request, sampled only while idle
//   entrada  - IN_WIDTH-bit unsigned value, captured on the accepting edge
//   busy     - conversion in progress
//   done     - one-cycle pulse when the new display value is valid
//   overflow - last accepted value exceeded 10^DIGITS-1
//   saida    - DIGITS 7-segment fields, digit i at [7i+6:7i], bit0=a..bit6=g
// Optional: define LEADING_ZERO_BLANK_EN to blank leading zero digits (ones digit never blanked).
module gerenciador_saidas_bcd_seq #(
    parameter int IN_WIDTH       = 8,
    parameter int DIGITS         = 3,
    parameter int SEG_ACTIVE_LOW = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start,
    input  logic [IN_WIDTH-1:0]   entrada,
    output logic                  busy,
    output logic                  done,
    output logic                  overflow,
    output logic [7*DIGITS-1:0]   saida
);
    localparam int BW = 4 * DIGITS;
    localparam int CW = IN_WIDTH > 1 ? $clog2(IN_WIDTH) : 1;
    localparam logic [6:0] POL = SEG_ACTIVE_LOW != 0 ? 7'h7F : 7'h00;

    function automatic logic [63:0] max_val(input int d);
        logic [63:0] p;
        p = 64'd1;
        for (int i = 0; i < d; i++) p = p * 64'd10;
        return p - 64'd1;
    endfunction

    localparam logic [63:0] MAX_VAL = max_val(DIGITS);

    function automatic logic [6:0] seg7(input logic [3:0] n);
        case (n)
            4'd0: seg7 = 7'h3F;
            4'd1: seg7 = 7'h06;
            4'd2: seg7 = 7'h5B;
            4'd3: seg7 = 7'h4F;
            4'd4: seg7 = 7'h66;
            4'd5: seg7 = 7'h6D;
            4'd6: seg7 = 7'h7D;
            4'd7: seg7 = 7'h07;
            4'd8: seg7 = 7'h7F;
            4'd9: seg7 = 7'h6F;
            default: seg7 = 7'h00;
        endcase
    endfunction

    typedef enum logic [1:0] {IDLE, CONV, LATCH} state_t;

    state_t              state, next_state;
    logic [IN_WIDTH-1:0] sh;
    logic [BW-1:0]       bcd, bcd_adj, disp;
    logic [CW-1:0]       cnt;
    logic                ovf_pend;

    always_ff @(posedge clk) begin
        if (!rst_n) state <= IDLE;
        else state <= next_state;
    end

    always_comb begin
        next_state = state == IDLE ? (start ? CONV : IDLE) :
                     state == CONV ? (cnt == '0 ? LATCH : CONV) : IDLE;
    end

    always_comb begin
        bcd_adj = bcd;
        for (int i = 0; i < DIGITS; i++)
            bcd_adj[4*i+:4] = bcd[4*i+:4] >= 4'd5 ? bcd[4*i+:4] + 4'd3 : bcd[4*i+:4];
    end

    // Work registers only move in CONV; the display register only on LATCH,
    // so saida stays frozen on the previous value for the whole conversion.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sh       <= '0;
            bcd      <= '0;
            cnt      <= '0;
            disp     <= '0;
            ovf_pend <= 1'b0;
            overflow <= 1'b0;
            done     <= 1'b0;
        end else begin
            done <= state == LATCH;
            if (state == IDLE && start) begin
                sh       <= entrada;
                bcd      <= '0;
                cnt      <= CW'(IN_WIDTH - 1);
                ovf_pend <= 64'(entrada) > MAX_VAL;
            end else if (state == CONV) begin
                {bcd, sh} <= {bcd_adj, sh} << 1;
                cnt       <= cnt - CW'(1);
            end else if (state == LATCH) begin
                disp     <= bcd;
                overflow <= ovf_pend;
            end
        end
    end

    always_comb begin
        busy  = state != IDLE;
        saida = '0;
        for (int i = 0; i < DIGITS; i++) begin
`ifdef LEADING_ZERO_BLANK_EN
            saida[7*i+:7] = (overflow ? 7'h40 :
                             (i > 0 && (disp >> (4*i)) == '0) ? 7'h00 : seg7(disp[4*i+:4])) ^ POL;
`else
            saida[7*i+:7] = (overflow ? 7'h40 : seg7(disp[4*i+:4])) ^ POL;
`endif
        end
    end
endmodule
